memory_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline, directly downstream of the Execute stage (EX/MEM register).
- Consumes the ALU result, store data, destination register and control bits, and resolves the branch decision.
- Performs data-memory reads and writes against an internal word RAM with configurable access latency, stalling upstream while busy.
- Drives the MEM/WB pipeline register consumed by write-back.

---
 rtl/memory_access_stage.sv | 141 ++++++++++++++
 tb/tb_memory_access_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data RAM with configurable latency, branch resolve, MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN (adds alignErr output).
module memory_access_stage #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  inPC,
    input  logic        zero,
    input  logic [31:0] aluResult,
    input  logic [31:0] writeData,
    input  logic [4:0]  inWr,
    input  logic        inBranch,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        inMemToReg,
    input  logic        inRegWrite,
    output logic        pcSrc,
    output logic [9:0]  branchTarget,
    output logic        stall,
    output logic [31:0] readData,
    output logic [31:0] outAluResult,
    output logic [4:0]  outWr,
    output logic        outMemToReg,
    output logic        outRegWrite
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        alignErr
`endif
);
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit ZERO_LAT = (LATENCY == 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        readData_q, readData_d;
    logic [31:0]        aluResult_q, aluResult_d;
    logic [4:0]         wr_q, wr_d;
    logic               memToReg_q, memToReg_d;
    logic               regWrite_q, regWrite_d;
    logic [31:0]        mem [DEPTH];
    logic [ADDR_W-1:0]  addr;
    logic               misaligned;
    logic               memOp;
    logic               accessNow;
    logic               memWe;

    assign addr = aluResult[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    logic alignErr_q, alignErr_d;
    assign misaligned = (inMemRead | inMemWrite) & (aluResult[1:0] != 2'b00);
    assign alignErr   = alignErr_q;
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned request is dropped entirely, so it never counts as a memory op.
    assign memOp     = (inMemRead | inMemWrite) & ~misaligned;
    assign accessNow = memOp & (ZERO_LAT | ((state_q == WAIT) && (cnt_q == '0)));
    assign stall     = reset & memOp & ~accessNow;
    assign memWe     = reset & accessNow & inMemWrite;

    assign pcSrc        = reset & inBranch & zero & ~stall;
    assign branchTarget = inPC;

    assign readData     = readData_q;
    assign outAluResult = aluResult_q;
    assign outWr        = wr_q;
    assign outMemToReg  = memToReg_q;
    assign outRegWrite  = regWrite_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        readData_d  = '0;
        aluResult_d = aluResult;
        wr_d        = inWr;
        memToReg_d  = inMemToReg;
        regWrite_d  = inRegWrite;
`ifdef MEM_ALIGN_CHECK_EN
        alignErr_d  = misaligned;
`endif
        if (stall) begin
            // Upstream is frozen, so MEM/WB receives a bubble while the access is in flight.
            aluResult_d = '0;
            wr_d        = '0;
            memToReg_d  = 1'b0;
            regWrite_d  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            alignErr_d  = 1'b0;
`endif
            if (state_q == IDLE) begin
                state_d = WAIT;
                cnt_d   = CNT_W'(LATENCY - 1);
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            state_d = IDLE;
            if (accessNow && inMemRead && !inMemWrite) readData_d = mem[addr];
            if (misaligned) regWrite_d = 1'b0;
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            readData_q  <= '0;
            aluResult_q <= '0;
            wr_q        <= '0;
            memToReg_q  <= 1'b0;
            regWrite_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            alignErr_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            readData_q  <= readData_d;
            aluResult_q <= aluResult_d;
            wr_q        <= wr_d;
            memToReg_q  <= memToReg_d;
            regWrite_q  <= regWrite_d;
`ifdef MEM_ALIGN_CHECK_EN
            alignErr_q  <= alignErr_d;
`endif
        end
    end

    // RAM keeps its contents across reset; memWe is already gated by reset.
    always_ff @(negedge clock) begin
        if (memWe) mem[addr] <= writeData;
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage (LATENCY=2, ADDR_W=8); covers alignErr when MEM_ALIGN_CHECK_EN is defined.
module tb_memory_access_stage;
    logic        clock;
    logic        reset;
    logic [9:0]  inPC;
    logic        zero;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic [4:0]  inWr;
    logic        inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite;
    logic        pcSrc;
    logic [9:0]  branchTarget;
    logic        stall;
    logic [31:0] readData;
    logic [31:0] outAluResult;
    logic [4:0]  outWr;
    logic        outMemToReg, outRegWrite;
`ifdef MEM_ALIGN_CHECK_EN
    logic        alignErr;
`endif

    memory_access_stage #(.ADDR_W(8), .LATENCY(2)) dut (
        .clock(clock), .reset(reset), .inPC(inPC), .zero(zero),
        .aluResult(aluResult), .writeData(writeData), .inWr(inWr),
        .inBranch(inBranch), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inMemToReg(inMemToReg), .inRegWrite(inRegWrite),
        .pcSrc(pcSrc), .branchTarget(branchTarget), .stall(stall),
        .readData(readData), .outAluResult(outAluResult), .outWr(outWr),
        .outMemToReg(outMemToReg), .outRegWrite(outRegWrite)
`ifdef MEM_ALIGN_CHECK_EN
        , .alignErr(alignErr)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        m2r;
        logic        rw;
        int          stalls;
        logic        aerr;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic issue_v = 1'b0;

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wb_or();
        return readData | outAluResult | {27'd0, outWr} | {30'd0, outMemToReg, outRegWrite};
    endfunction

    // Monitor: samples on the rising edge, opposite to the DUT's active falling edge.
    initial begin
        logic pend, pend_bub;
        int   scnt, got_st;
        exp_t e;
        pend = 0; pend_bub = 0; scnt = 0; got_st = 0;
        forever begin
            @(posedge clock);
            if (!reset) begin
                pend = 0; pend_bub = 0; scnt = 0;
            end else begin
                if (pend_bub) chk("bubble", wb_or(), 32'd0);
                if (pend) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("readData", readData, e.rdata);
                        chk("outAluResult", outAluResult, e.alu);
                        chk("outWr", {27'd0, outWr}, {27'd0, e.wr});
                        chk("outMemToReg", {31'd0, outMemToReg}, {31'd0, e.m2r});
                        chk("outRegWrite", {31'd0, outRegWrite}, {31'd0, e.rw});
                        chk("stall_cycles", got_st, e.stalls);
`ifdef MEM_ALIGN_CHECK_EN
                        chk("alignErr", {31'd0, alignErr}, {31'd0, e.aerr});
`endif
                    end
                end
                pend = 0; pend_bub = 0;
                if (issue_v) begin
                    if (stall) begin
                        scnt++;
                        pend_bub = 1;
                    end else begin
                        pend = 1;
                        got_st = scnt;
                        scnt = 0;
                    end
                end
            end
        end
    end

    task automatic idle();
        issue_v = 1'b0;
        inBranch = 0; zero = 0; inPC = '0;
        inMemRead = 0; inMemWrite = 0; inMemToReg = 0; inRegWrite = 0;
        aluResult = '0; writeData = '0; inWr = '0;
    endtask

    // Called just after a falling edge; returns just after the edge that commits the instruction.
    task automatic issue(input logic rd, input logic wm, input logic m2r, input logic rw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst,
                         input logic [31:0] exp_rd, input logic exp_rw, input int exp_st,
                         input logic exp_aerr);
        exp_t e;
        int   n;
        inMemRead = rd; inMemWrite = wm; inMemToReg = m2r; inRegWrite = rw;
        aluResult = alu; writeData = wd; inWr = dst;
        issue_v = 1'b1;
        e.rdata = exp_rd; e.alu = alu; e.wr = dst; e.m2r = m2r; e.rw = exp_rw;
        e.stalls = exp_st; e.aerr = exp_aerr;
        q.push_back(e);
        #1;
        chk("pcSrc", {31'd0, pcSrc}, {31'd0, inBranch & zero & (exp_st == 0)});
        chk("branchTarget", {22'd0, branchTarget}, {22'd0, inPC});
        n = 0;
        do begin
            @(posedge clock);
            n++;
        end while (stall && n < 20);
        if (stall) chk("stall_timeout", 32'd1, 32'd0);
        @(negedge clock);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        inBranch = 1; zero = 1; inMemRead = 1; aluResult = 32'h40;
        #2;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_pcSrc", {31'd0, pcSrc}, 32'd0);
        chk("rst_outputs", wb_or(), 32'd0);
        @(negedge clock);
        #1;
        chk("rst_outputs_edge", wb_or(), 32'd0);
        idle();
        reset = 1'b1;
        @(negedge clock);
        #1;

        // ALU passthrough
        issue(0, 0, 0, 1, 32'h7, 32'h0, 5'd5, 32'h0, 1, 0, 0);
        // Store then load back-to-back
        issue(0, 1, 0, 0, 32'h40, 32'h12345678, 5'd0, 32'h0, 0, 2, 0);
        issue(1, 0, 1, 1, 32'h40, 32'h0, 5'd8, 32'h12345678, 1, 2, 0);
        // Branch taken / not taken
        inBranch = 1; zero = 1; inPC = 10'h3A;
        issue(0, 0, 0, 0, 32'h100, 32'h0, 5'd0, 32'h0, 0, 0, 0);
        zero = 0;
        issue(0, 0, 0, 0, 32'h104, 32'h0, 5'd0, 32'h0, 0, 0, 0);
        // Branch under a stalling load: pcSrc held low while stalled
        zero = 1; inPC = 10'h15;
        issue(1, 0, 1, 1, 32'h40, 32'h0, 5'd9, 32'h12345678, 1, 2, 0);
        idle();
        @(negedge clock);
        #1;
        // Address wrap and read/write priority
        issue(0, 1, 0, 0, 32'h400, 32'hA5, 5'd0, 32'h0, 0, 2, 0);
        issue(1, 0, 1, 1, 32'h000, 32'h0, 5'd4, 32'hA5, 1, 2, 0);
        issue(1, 1, 1, 1, 32'h80, 32'h5555, 5'd6, 32'h0, 1, 2, 0);
        issue(1, 0, 1, 1, 32'h80, 32'h0, 5'd7, 32'h5555, 1, 2, 0);
`ifdef MEM_ALIGN_CHECK_EN
        issue(1, 0, 1, 1, 32'h41, 32'h0, 5'd2, 32'h0, 0, 0, 1);
        issue(0, 1, 0, 0, 32'h42, 32'hBAD, 5'd0, 32'h0, 0, 0, 1);
        issue(1, 0, 1, 1, 32'h40, 32'h0, 5'd2, 32'h12345678, 1, 2, 0);
`endif

        // Abort a store mid-WAIT with reset; RAM must keep the prior word
        issue(0, 1, 0, 0, 32'h10, 32'h11111111, 5'd0, 32'h0, 0, 2, 0);
        inMemRead = 0; inMemWrite = 1; inMemToReg = 0; inRegWrite = 0;
        aluResult = 32'h10; writeData = 32'hDEADBEEF; inWr = '0;
        @(posedge clock);
        @(negedge clock);
        #2;
        chk("wait_stall", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_outputs", wb_or(), 32'd0);
        idle();
        @(negedge clock);
        #1;
        reset = 1'b1;
        issue(1, 0, 1, 1, 32'h10, 32'h0, 5'd3, 32'h11111111, 1, 2, 0);

        idle();
        repeat (3) @(negedge clock);
        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
